// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller port between the ROM loader,
// CPU cartridge reads, an auxiliary read/write port and refresh. One command
// is in flight at a time. Command strobes and acks are registered one-cycle pulses.
module sdram_port_arbiter #(
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_din,
    output logic          ld_ack,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_word,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_din,
    input  logic          aux_word,
    output logic [DW-1:0] aux_dout,
    output logic          aux_ack,
    input  logic          refresh_req,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          mem_refresh,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_word,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_busy
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_COMPLETE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OWN_LD  = 2'd0,
        OWN_CPU = 2'd1,
        OWN_AUX = 2'd2,
        OWN_REF = 2'd3
    } owner_t;

    state_t        state;
    owner_t        owner;
    logic          cmd_wr;
    logic          ref_pend;
    logic          rr;        // 0: CPU wins the next contended grant, 1: aux
    logic [TW-1:0] tmo_cnt;
    logic          any_ack;
    logic          aux_win;

    // The cycle an ack is visible the requester still holds req, so IDLE
    // skips arbitration then; a req still high one cycle later is a new request.
    assign any_ack = ld_ack | cpu_ack | aux_ack;
    assign aux_win = aux_req && (!cpu_req || rr);

    // Command sequencer: arbitrate, issue, wait on the controller, complete.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            owner       <= OWN_LD;
            cmd_wr      <= 1'b0;
            ref_pend    <= 1'b0;
            rr          <= 1'b0;
            tmo_cnt     <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_refresh <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_word    <= 1'b0;
            ld_ack      <= 1'b0;
            cpu_ack     <= 1'b0;
            aux_ack     <= 1'b0;
            cpu_dout    <= '0;
            aux_dout    <= '0;
        end else begin
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_refresh <= 1'b0;
            ld_ack      <= 1'b0;
            cpu_ack     <= 1'b0;
            aux_ack     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!any_ack) begin
                        if (ld_req) begin
                            owner    <= OWN_LD;
                            cmd_wr   <= 1'b1;
                            mem_wr   <= 1'b1;
                            mem_addr <= ld_addr;
                            mem_din  <= ld_din;
                            mem_word <= 1'b1;
                            state    <= S_ISSUE;
                        end else if (ref_pend) begin
                            owner       <= OWN_REF;
                            cmd_wr      <= 1'b0;
                            mem_refresh <= 1'b1;
                            state       <= S_ISSUE;
                        end else if (aux_win) begin
                            owner    <= OWN_AUX;
                            cmd_wr   <= aux_we;
                            mem_wr   <= aux_we;
                            mem_rd   <= !aux_we;
                            mem_addr <= aux_addr;
                            mem_din  <= aux_din;
                            mem_word <= aux_word;
                            if (cpu_req) rr <= 1'b0;
                            state    <= S_ISSUE;
                        end else if (cpu_req) begin
                            owner    <= OWN_CPU;
                            cmd_wr   <= 1'b0;
                            mem_rd   <= 1'b1;
                            mem_addr <= cpu_addr;
                            mem_word <= cpu_word;
                            if (aux_req) rr <= 1'b1;
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    if (owner == OWN_REF) ref_pend <= 1'b0;
                    state   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // A controller that never shows busy must not hang the port.
                    if (mem_busy)
                        state <= S_WAIT_DONE;
                    else if (tmo_cnt == TW'(TIMEOUT - 1))
                        state <= S_COMPLETE;
                    else
                        tmo_cnt <= tmo_cnt + 1'b1;
                end
                S_WAIT_DONE: begin
                    if (!mem_busy) state <= S_COMPLETE;
                end
                S_COMPLETE: begin
                    case (owner)
                        OWN_LD:  ld_ack <= 1'b1;
                        OWN_CPU: begin
                            cpu_ack <= 1'b1;
                            if (!cmd_wr) cpu_dout <= mem_dout;
                        end
                        OWN_AUX: begin
                            aux_ack <= 1'b1;
                            if (!cmd_wr) aux_dout <= mem_dout;
                        end
                        default: ;
                    endcase
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // Refresh strobes are latched in any state; repeats collapse.
            if (refresh_req) ref_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a simple busy-responding memory model.
module tb_sdram_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TIMEOUT = 64;

    logic          clk, reset;
    logic          ld_req, ld_ack, cpu_req, cpu_word, cpu_ack;
    logic          aux_req, aux_we, aux_word, aux_ack, refresh_req;
    logic [AW-1:0] ld_addr, cpu_addr, aux_addr, mem_addr;
    logic [DW-1:0] ld_din, cpu_dout, aux_din, aux_dout, mem_din, mem_dout;
    logic          mem_rd, mem_wr, mem_refresh, mem_word, mem_busy;

    sdram_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_word(cpu_word),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_din(aux_din),
        .aux_word(aux_word), .aux_dout(aux_dout), .aux_ack(aux_ack),
        .refresh_req(refresh_req),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_word(mem_word),
        .mem_dout(mem_dout), .mem_busy(mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: busy rises after a strobe and is seen high for busy_len cycles.
    bit          no_busy = 1'b0;
    int          busy_len = 1;
    logic [15:0] rdata = 16'h0;
    int          rem = 0;
    initial begin
        mem_busy = 1'b0;
        mem_dout = '0;
        forever begin
            @(negedge clk);
            if (mem_rd | mem_wr | mem_refresh) begin
                if (no_busy) mem_dout = rdata;
                else begin
                    mem_busy = 1'b1;
                    rem = busy_len + 1;
                end
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    mem_busy = 1'b0;
                    mem_dout = rdata;
                end
            end
        end
    end

    // Command/ack monitor.
    typedef struct {
        int          kind;   // 1 rd, 2 wr, 3 refresh
        logic [23:0] addr;
        logic [15:0] din;
        logic        word;
        int          c;
    } cmd_t;
    cmd_t cmd_q[$];
    int   multi_ack = 0;
    int   multi_strobe = 0;
    int   cpu_ack_n = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rd | mem_wr | mem_refresh) begin
                cmd_t e;
                e.kind = mem_rd ? 1 : (mem_wr ? 2 : 3);
                e.addr = mem_addr;
                e.din  = mem_din;
                e.word = mem_word;
                e.c    = cyc;
                cmd_q.push_back(e);
            end
            if (int'(mem_rd) + int'(mem_wr) + int'(mem_refresh) > 1) multi_strobe++;
            if (int'(ld_ack) + int'(cpu_ack) + int'(aux_ack) > 1) multi_ack++;
            if (cpu_ack) cpu_ack_n++;
        end
    end

    function automatic logic ack_of(input int who);
        case (who)
            0:       return ld_ack;
            1:       return cpu_ack;
            default: return aux_ack;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input int who, input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (ack_of(who)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check($sformatf("timeout_ack%0d", who), 64'd0, 64'd1);
    endtask

    initial begin
        int n0, at, nref, nwr, cpu_before;
        int ord[4];
        bit found;

        reset = 1'b1;
        ld_req = 0; ld_addr = '0; ld_din = '0;
        cpu_req = 0; cpu_addr = '0; cpu_word = 0;
        aux_req = 0; aux_we = 0; aux_addr = '0; aux_din = '0; aux_word = 0;
        refresh_req = 0;

        // Reset state
        tick(3);
        check("rst_strobes", {mem_rd, mem_wr, mem_refresh, mem_word}, 4'b0);
        check("rst_acks", {ld_ack, cpu_ack, aux_ack}, 3'b0);
        check("rst_addr_din", {mem_addr, mem_din}, 40'h0);
        check("rst_douts", {cpu_dout, aux_dout}, 32'h0);
        check("rst_state", 64'(dut.state), 64'd0);
        check("rst_refpend_rr", {dut.ref_pend, dut.rr}, 2'b00);
        reset = 1'b0;
        tick(2);

        // CPU word read, busy for 3 cycles
        cmd_q.delete();
        busy_len = 3; rdata = 16'hBEEF;
        cpu_req = 1; cpu_addr = 24'h001234; cpu_word = 1;
        n0 = cyc;
        wait_ack(1, 30, at);
        cpu_req = 0;
        check("cpu_rd_latency", 64'(at - n0), 64'd7);
        check("cpu_rd_dout", 64'(cpu_dout), 64'hBEEF);
        check("cpu_rd_ncmd", 64'(cmd_q.size()), 64'd1);
        if (cmd_q.size() >= 1) begin
            check("cpu_rd_kind", 64'(cmd_q[0].kind), 64'd1);
            check("cpu_rd_addr_word", {cmd_q[0].addr, cmd_q[0].word}, {24'h001234, 1'b1});
        end
        tick(1);
        check("cpu_ack_pulse", 64'(cpu_ack), 64'd0);
        tick(2);

        // Aux read absorbed with no busy: forced completion
        no_busy = 1; rdata = 16'h5A5A;
        aux_req = 1; aux_we = 0; aux_addr = 24'h000ABC; aux_word = 1;
        n0 = cyc;
        wait_ack(2, TIMEOUT + 20, at);
        aux_req = 0;
        check("aux_tmo_latency", 64'(at - n0), 64'(TIMEOUT + 3));
        check("aux_tmo_dout", 64'(aux_dout), 64'h5A5A);
        check("aux_tmo_state_idle", 64'(dut.state), 64'd0);
        no_busy = 0;
        tick(3);

        // CPU and aux both held: strict alternation starting with CPU
        cmd_q.delete();
        busy_len = 1;
        cpu_req = 1; cpu_addr = 24'h000200; cpu_word = 1;
        aux_req = 1; aux_we = 1; aux_addr = 24'h000010; aux_din = 16'h00A5; aux_word = 0;
        for (int k = 0; k < 4; k++) begin
            ord[k] = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (cpu_ack | aux_ack) begin
                    ord[k] = cpu_ack ? 1 : 2;
                    break;
                end
            end
        end
        cpu_req = 0; aux_req = 0;
        for (int k = 0; k < 4; k++)
            check($sformatf("rr_order%0d", k), 64'(ord[k]), 64'((k % 2 == 0) ? 1 : 2));
        tick(3);
        check("rr_ncmd", 64'(cmd_q.size()), 64'd4);
        if (cmd_q.size() >= 2) begin
            check("rr_cpu_cmd", {8'(cmd_q[0].kind), cmd_q[0].addr}, {8'd1, 24'h000200});
            check("rr_aux_cmd", {8'(cmd_q[1].kind), cmd_q[1].addr, cmd_q[1].din, cmd_q[1].word},
                  {8'd2, 24'h000010, 16'h00A5, 1'b0});
        end

        // Loader burst of 8 with CPU and refresh arriving mid-burst
        cmd_q.delete();
        busy_len = 1; rdata = 16'h7777;
        ld_req = 1; ld_addr = 24'h100000; ld_din = 16'h1000;
        for (int i = 0; i < 8; i++) begin
            wait_ack(0, 20, at);
            if (i == 7) ld_req = 0;
            ld_addr = ld_addr + 1'b1;
            ld_din  = ld_din + 1'b1;
            if (i == 1) begin
                cpu_req = 1; cpu_addr = 24'h000300; cpu_word = 0;
            end
            if (i == 3) begin
                refresh_req = 1;
                tick(1);
                refresh_req = 0;
            end
        end
        wait_ack(1, 40, at);
        cpu_req = 0;
        check("ld_cpu_dout", 64'(cpu_dout), 64'h7777);
        check("ld_ncmd", 64'(cmd_q.size()), 64'd10);
        nwr = 0;
        for (int i = 0; i < 8 && i < cmd_q.size(); i++)
            if (cmd_q[i].kind == 2 && cmd_q[i].word == 1'b1) nwr++;
        check("ld_wr_word_count", 64'(nwr), 64'd8);
        if (cmd_q.size() >= 10) begin
            check("ld_first_addr", 64'(cmd_q[0].addr), 64'h100000);
            check("ld_last_addr_din", {cmd_q[7].addr, cmd_q[7].din}, {24'h100007, 16'h1007});
            check("ld_then_refresh", 64'(cmd_q[8].kind), 64'd3);
            check("ld_then_cpu_rd", {8'(cmd_q[9].kind), cmd_q[9].addr}, {8'd1, 24'h000300});
        end
        tick(3);

        // Three refresh pulses during one CPU read collapse into one refresh
        cmd_q.delete();
        busy_len = 6; rdata = 16'h4444;
        cpu_req = 1; cpu_addr = 24'h000400; cpu_word = 1;
        tick(2);
        for (int p = 0; p < 3; p++) begin
            refresh_req = 1;
            tick(1);
            refresh_req = 0;
            tick(1);
        end
        wait_ack(1, 30, at);
        cpu_req = 0;
        tick(16);
        nref = 0;
        for (int i = 0; i < cmd_q.size(); i++) if (cmd_q[i].kind == 3) nref++;
        check("refcol_count", 64'(nref), 64'd1);
        check("refcol_ncmd", 64'(cmd_q.size()), 64'd2);
        if (cmd_q.size() >= 2) begin
            check("refcol_order", {8'(cmd_q[0].kind), 8'(cmd_q[1].kind)}, {8'd1, 8'd3});
            check("refcol_after_ack", 64'(cmd_q[1].c > at), 64'd1);
        end
        check("refcol_dout", 64'(cpu_dout), 64'h4444);

        // Reset during WAIT_DONE aborts silently
        cpu_before = cpu_ack_n;
        busy_len = 10; rdata = 16'h9999;
        cpu_req = 1; cpu_addr = 24'h000500; cpu_word = 1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut.state == 3'd3) begin
                found = 1;
                break;
            end
        end
        check("rstmid_reached_wait_done", 64'(found), 64'd1);
        reset = 1; cpu_req = 0;
        tick(1);
        check("rstmid_strobes_acks", {mem_rd, mem_wr, mem_refresh, ld_ack, cpu_ack, aux_ack}, 6'b0);
        check("rstmid_state", 64'(dut.state), 64'd0);
        check("rstmid_cpu_dout", 64'(cpu_dout), 64'd0);
        reset = 0;
        for (int i = 0; i < 30 && mem_busy; i++) tick(1);
        tick(2);
        check("rstmid_no_ack", 64'(cpu_ack_n - cpu_before), 64'd0);
        busy_len = 2; rdata = 16'h1357;
        cpu_req = 1; cpu_addr = 24'h000600; cpu_word = 1;
        n0 = cyc;
        wait_ack(1, 30, at);
        cpu_req = 0;
        check("rstmid_fresh_latency", 64'(at - n0), 64'd6);
        check("rstmid_fresh_dout", 64'(cpu_dout), 64'h1357);
        tick(3);
        check("rstmid_one_ack", 64'(cpu_ack_n - cpu_before), 64'd1);

        check("never_two_acks", 64'(multi_ack), 64'd0);
        check("never_two_strobes", 64'(multi_strobe), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
